// File: rtl/fuzzy_sweep_engine.sv
// 2-D grid sweep for the fuzzy controller: drives both inputs, waits a settle time,
// captures the defuzzified output and streams (index, data) over valid/ready.
module fuzzy_sweep_engine #(
    parameter int DATA_W     = 8,
    parameter int MIN_VAL    = 1,
    parameter int MAX_VAL    = 254,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 20,
    parameter int IDX_W      = 16
) (
    input  logic              clk_0,
    input  logic              Srst,
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] Entrada_01,
    output logic [DATA_W-1:0] Entrada_02,
    output logic              EN_REGRAS,
    input  logic [DATA_W-1:0] saida_defuzzy,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [DATA_W-1:0] sample_data,
    output logic [IDX_W-1:0]  sample_idx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [DATA_W-1:0] MIN_D       = DATA_W'(MIN_VAL);
    // One extra bit so that value+STEP past 2^DATA_W is seen as out of range
    localparam logic [DATA_W:0]   MAX_W       = (DATA_W+1)'(MAX_VAL);
    localparam logic [DATA_W:0]   STEP_W      = (DATA_W+1)'(STEP);

    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, HOLD, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic [IDX_W-1:0] idx;
    logic [DATA_W:0]  next_e1;
    logic [DATA_W:0]  next_e2;

    assign next_e1 = {1'b0, Entrada_01} + STEP_W;
    assign next_e2 = {1'b0, Entrada_02} + STEP_W;

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            idx          <= '0;
            Entrada_01   <= MIN_D;
            Entrada_02   <= MIN_D;
            EN_REGRAS    <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_idx   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            // Abort beats start and beats a same-edge transfer in HOLD
            state        <= IDLE;
            settle_cnt   <= '0;
            Entrada_01   <= MIN_D;
            Entrada_02   <= MIN_D;
            EN_REGRAS    <= 1'b0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        idx        <= '0;
                        Entrada_01 <= MIN_D;
                        Entrada_02 <= MIN_D;
                        EN_REGRAS  <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    sample_data  <= saida_defuzzy;
                    sample_idx   <= idx;
                    sample_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        idx          <= idx + 1'b1;
                        if (next_e2 <= MAX_W) begin
                            Entrada_02 <= next_e2[DATA_W-1:0];
                            state      <= SETTLE;
                        end else if (next_e1 <= MAX_W) begin
                            Entrada_01 <= next_e1[DATA_W-1:0];
                            Entrada_02 <= MIN_D;
                            state      <= SETTLE;
                        end else begin
                            state     <= DONE;
                            EN_REGRAS <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_sweep_engine.sv
// Scoreboard bench: a small 3x3 grid engine for handshake/abort/reset cases
// and a 16x16 grid engine for the wide sweep; controller modelled as Entrada_01^Entrada_02.
module tb_fuzzy_sweep_engine;

    typedef struct {
        int idx;
        int data;
        int e1;
        int e2;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small engine: MIN=1 MAX=5 STEP=2 SETTLE=3
    logic       srst, start, abort, ready;
    logic [7:0] e1, e2, saida, sdata;
    logic [15:0] sidx;
    logic       en, valid, busy, done;

    assign saida = e1 ^ e2;

    fuzzy_sweep_engine #(.DATA_W(8), .MIN_VAL(1), .MAX_VAL(5), .STEP(2), .SETTLE_CYC(3), .IDX_W(16)) u1 (
        .clk_0(clk), .Srst(srst), .start(start), .abort(abort),
        .Entrada_01(e1), .Entrada_02(e2), .EN_REGRAS(en), .saida_defuzzy(saida),
        .sample_valid(valid), .sample_ready(ready), .sample_data(sdata), .sample_idx(sidx),
        .busy(busy), .done(done)
    );

    // Wide engine: MIN=1 MAX=254 STEP=16 SETTLE=1
    logic       rst2, start2;
    logic [7:0] f1, f2, saida2, sdata2;
    logic [15:0] sidx2;
    logic       en2, valid2, busy2, done2;

    assign saida2 = f1 ^ f2;

    fuzzy_sweep_engine #(.DATA_W(8), .MIN_VAL(1), .MAX_VAL(254), .STEP(16), .SETTLE_CYC(1), .IDX_W(16)) u2 (
        .clk_0(clk), .Srst(rst2), .start(start2), .abort(1'b0),
        .Entrada_01(f1), .Entrada_02(f2), .EN_REGRAS(en2), .saida_defuzzy(saida2),
        .sample_valid(valid2), .sample_ready(1'b1), .sample_data(sdata2), .sample_idx(sidx2),
        .busy(busy2), .done(done2)
    );

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor for the small engine: transfers and hold stability
    logic        have_hold = 1'b0;
    logic [7:0]  hold_data, hold_e1, hold_e2;
    logic [15:0] hold_idx;

    always @(negedge clk) begin
        if (valid && ready && !abort && !srst) begin
            have_hold <= 1'b0;
            if (q1.size() == 0) begin
                check("u1 unexpected sample idx", sidx, -1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("u1 idx", sidx, e.idx);
                check("u1 data", sdata, e.data);
                check("u1 Entrada_01", e1, e.e1);
                check("u1 Entrada_02", e2, e.e2);
            end
        end else if (valid && !ready) begin
            if (have_hold) begin
                check("hold data stable", sdata, hold_data);
                check("hold idx stable", sidx, hold_idx);
                check("hold Entrada_01 frozen", e1, hold_e1);
                check("hold Entrada_02 frozen", e2, hold_e2);
            end
            have_hold <= 1'b1;
            hold_data <= sdata;
            hold_idx  <= sidx;
            hold_e1   <= e1;
            hold_e2   <= e2;
        end else begin
            have_hold <= 1'b0;
        end
    end

    // Monitor for the wide engine
    int max_in2 = 0;
    int count2  = 0;

    always @(negedge clk) begin
        if (!rst2) begin
            if (int'(f1) > max_in2) max_in2 = int'(f1);
            if (int'(f2) > max_in2) max_in2 = int'(f2);
            if (valid2) begin
                count2++;
                if (q2.size() == 0) begin
                    check("u2 unexpected sample idx", sidx2, -1);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    check("u2 idx", sidx2, e.idx);
                    check("u2 data", sdata2, e.data);
                    check("u2 Entrada_01", f1, e.e1);
                    check("u2 Entrada_02", f2, e.e2);
                end
            end
        end
    end

    // Hand-computed 3x3 grid: coordinates and expected controller output (a^b)
    int g_a[9] = '{1, 1, 1, 3, 3, 3, 5, 5, 5};
    int g_b[9] = '{1, 3, 5, 1, 3, 5, 1, 3, 5};
    int g_d[9] = '{0, 2, 4, 2, 0, 6, 4, 6, 0};

    task automatic push_grid1();
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            e.idx = i; e.data = g_d[i]; e.e1 = g_a[i]; e.e2 = g_b[i];
            q1.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done1(string name, int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, done, 1);
    endtask

    task automatic check_idle(string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " EN_REGRAS"}, en, 0);
        check({tag, " valid"}, valid, 0);
        check({tag, " done"}, done, 0);
        check({tag, " Entrada_01"}, e1, 1);
        check({tag, " Entrada_02"}, e2, 1);
    endtask

    initial begin
        int n;
        srst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        rst2 = 1'b1; start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset sample_data", sdata, 0);
        check("reset sample_idx", sidx, 0);
        srst = 1'b0; rst2 = 1'b0;

        // Wide grid: 16 points per axis, last at (241,241) idx 255
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                exp_t e;
                e.idx = a * 16 + b; e.e1 = 1 + 16 * a; e.e2 = 1 + 16 * b;
                e.data = e.e1 ^ e.e2;
                q2.push_back(e);
            end
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (!done2 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("u2 done", done2, 1);
        check("u2 samples", count2, 256);
        check("u2 queue drained", q2.size(), 0);
        check("u2 max input", max_in2, 241);
        check("u2 last idx", sidx2, 255);

        // Ready tied high: 9 samples in order, first-sample latency
        push_grid1();
        ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start busy", busy, 1);
        check("start EN_REGRAS", en, 1);
        n = 0;
        while (!valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("first valid latency", n, 4);
        wait_done1("sweep1 done", 100);
        check("sweep1 busy after done", busy, 0);
        check("sweep1 queue drained", q1.size(), 0);
        check("sweep1 last idx", sidx, 8);

        // Backpressure: ready high one cycle in three, restarting from DONE
        push_grid1();
        ready = 1'b0;
        pulse_start();
        check("restart clears done", done, 0);
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            ready = (n % 3 == 0);
            n++;
        end
        check("backpressure done", done, 1);
        check("backpressure queue drained", q1.size(), 0);

        // Abort at idx 4 on the same edge as ready in HOLD
        push_grid1();
        ready = 1'b1;
        pulse_start();
        n = 0;
        while (!(valid && sidx == 16'd4) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached idx 4", sidx, 4);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check_idle("abort");
        check("abort leaves idx 4..8 untransferred", q1.size(), 5);
        q1.delete();
        push_grid1();
        pulse_start();
        wait_done1("post-abort sweep done", 100);
        check("post-abort queue drained", q1.size(), 0);

        // Srst during SETTLE of point 2
        push_grid1();
        pulse_start();
        n = 0;
        while (!(valid && sidx == 16'd1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1 srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        check_idle("mid reset");
        check("mid reset sample_data", sdata, 0);
        check("mid reset sample_idx", sidx, 0);
        check("mid reset leaves idx 2..8", q1.size(), 7);
        q1.delete();

        // start and abort together while idle
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check_idle("start+abort");

        push_grid1();
        pulse_start();
        wait_done1("final sweep done", 100);
        check("final queue drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
